rx_mem_ctrl: RTL and testbench
==============================

Name: rx_mem_ctrl

Overview:
- Owns the single-port RX packet memory behind the Vthernet MAC.
- Sequences UDP payload bytes from the receive datapath into the memory and shares the one memory port with Wishbone-side reads.
- Holds one frame at a time under a buffer-ownership state machine: EMPTY, then RECV, then READY, then released by the host.

Parameters:
- OCT, 8, data byte width.
- ADDR_W, 11, memory address width; depth is 2**ADDR_W bytes.
- CNT_W, 16, width of the drop counter and the frame counter.

Ports:
- wb_clk_i  in  1  single clock for the block and the memory.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- rx_udp_data_v  in  1  payload byte valid; a frame is one contiguous high run.
- rx_udp_data  in  OCT  payload byte.
- rd_req  in  1  host read request; held high until rd_ack.
- rd_addr  in  ADDR_W  host read byte address; stable while rd_req is high.
- rd_ack  out  1  one-cycle pulse; rd_data is valid this cycle.
- rd_data  out  OCT  read data.
- buf_release  in  1  host pulse that frees a READY buffer.
- mem_en  out  1  memory port enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  OCT  memory write data.
- mem_rdata  in  OCT  memory read data; 1-cycle latency after mem_en with mem_we low.
- buf_ready  out  1  high while in READY.
- rx_len  out  ADDR_W+1  byte count of the held frame.
- rx_ovf  out  1  held frame was truncated.
- rx_irq  out  1  one-cycle pulse on RECV to READY.
- drop_cnt  out  CNT_W  saturating count of dropped frames.

Behaviour:
- Reset (asynchronous, wb_rst_ni low):
  - State goes to EMPTY.
  - All outputs are 0. This includes rx_len, rx_ovf, drop_cnt, rd_ack and the mem_* outputs.
  - The internal in_frame flag is set to the current rx_udp_data_v value, so a frame already in progress at reset release is ignored.
- Frame start: rx_udp_data_v is high and the registered previous valid is low. Frame end: valid falls.
- Valid held high continuously from reset, or from mid-frame, is never treated as a start.
- EMPTY:
  - On a frame start, go to RECV, write the first byte at address 0 in the same cycle, and set the write pointer to 1.
- RECV:
  - Each valid byte is written at the write pointer, which then increments.
  - When the pointer reaches 2**ADDR_W, further bytes are discarded and rx_ovf is set; the pointer does not wrap.
  - On frame end: rx_len gets the byte count (saturating at 2**ADDR_W), state goes to READY, and rx_irq pulses in the same cycle.
  - buf_release is ignored in RECV.
- READY:
  - Memory writes are blocked.
  - Any frame start increments drop_cnt, saturating at all-ones; the whole frame is discarded.
  - buf_release returns the state to EMPTY on the next edge and clears rx_ovf; rx_len keeps its value.
  - If buf_release and a frame start occur in the same cycle, the frame is dropped and counted, and the state still goes to EMPTY.
- Port arbitration:
  - A write has absolute priority; the receive stream is never stalled.
  - A read is granted in any cycle with no write, in every state.
  - Grant drives mem_en=1, mem_we=0 and mem_addr=rd_addr.
  - rd_ack and rd_data=mem_rdata follow exactly 1 cycle after the grant.
  - Only one read is outstanding at a time. rd_req seen in the rd_ack cycle is not regranted until the following cycle.
- mem_* outputs are combinational from state and inputs. mem_wdata equals rx_udp_data.

Optional Feature:
- Macro RX_MEM_STATS_EN.
- When defined:
  - Adds output rx_frame_cnt [CNT_W-1:0], a saturating count of frames accepted into the buffer (each EMPTY to RECV).
  - Adds output ovf_cnt [CNT_W-1:0], a saturating count of truncated frames.
  - Both reset to 0.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- 64-byte frame 0x00..0x3F from EMPTY:
  - Memory writes go to addresses 0..63 with matching data.
  - rx_irq pulses once on the cycle valid falls; rx_len=64; buf_ready=1; rx_ovf=0.
- Host reads addresses 0, 31 and 63 in READY: rd_ack comes 1 cycle after each grant, with rd_data 0x00, 0x1F and 0x3F.
- Read request issued mid-frame:
  - No grant while valid is high.
  - Grant occurs in the first idle cycle after the frame; rd_ack follows the next cycle with correct data.
- Frame of 2**ADDR_W+10 bytes:
  - Only addresses 0..2047 are written; no wrap back to address 0.
  - rx_len=2048, rx_ovf=1.
- Three frames arriving in READY: drop_cnt=3 and memory is untouched. After buf_release, the next frame is written from address 0.
- Reset boundary cases:
  - Reset released with valid already high: no write occurs until valid falls and rises again.
  - Reset asserted during RECV: outputs clear immediately; the next frame start is written from address 0.

Source files
------------

// File: rtl/rx_mem_ctrl.sv
// rtl/rx_mem_ctrl.sv - RX packet memory owner and port arbiter (optional stats: RX_MEM_STATS_EN)
module rx_mem_ctrl #(
    parameter int OCT    = 8,
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              rx_udp_data_v,
    input  logic [OCT-1:0]    rx_udp_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [OCT-1:0]    rd_data,
    input  logic              buf_release,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [OCT-1:0]    mem_wdata,
    input  logic [OCT-1:0]    mem_rdata,
    output logic              buf_ready,
    output logic [ADDR_W:0]   rx_len,
    output logic              rx_ovf,
    output logic              rx_irq,
`ifdef RX_MEM_STATS_EN
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  rx_frame_cnt,
    output logic [CNT_W-1:0]  ovf_cnt
`else
    output logic [CNT_W-1:0]  drop_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_RECV  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]  PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic              in_frame_q, in_frame_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rx_len_q, rx_len_d;
    logic              rx_ovf_q, rx_ovf_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              rd_ack_q, rd_ack_d;
`ifdef RX_MEM_STATS_EN
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
`endif

    logic              frame_start;
    logic              ptr_full;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_grant;
    logic              irq;

    // Buffer ownership FSM: decides writes, frame bookkeeping and drop accounting
    always_comb begin
        state_d     = state_q;
        in_frame_d  = rx_udp_data_v;
        wr_ptr_d    = wr_ptr_q;
        rx_len_d    = rx_len_q;
        rx_ovf_d    = rx_ovf_q;
        drop_cnt_d  = drop_cnt_q;
        wr_en       = 1'b0;
        wr_addr     = '0;
        irq         = 1'b0;
        frame_start = rx_udp_data_v & ~in_frame_q;
        ptr_full    = wr_ptr_q[ADDR_W];
`ifdef RX_MEM_STATS_EN
        frame_cnt_d = frame_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (frame_start) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    wr_ptr_d = PTR_ONE;
                    rx_ovf_d = 1'b0;
                    state_d  = ST_RECV;
`ifdef RX_MEM_STATS_EN
                    if (frame_cnt_q != CNT_MAX) frame_cnt_d = frame_cnt_q + CNT_ONE;
`endif
                end
            end
            ST_RECV: begin
                if (rx_udp_data_v) begin
                    if (!ptr_full) begin
                        wr_en    = 1'b1;
                        wr_addr  = wr_ptr_q[ADDR_W-1:0];
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end else begin
                        // Buffer is full: byte is dropped, pointer parks at depth
                        rx_ovf_d = 1'b1;
`ifdef RX_MEM_STATS_EN
                        if (!rx_ovf_q && ovf_cnt_q != CNT_MAX) ovf_cnt_d = ovf_cnt_q + CNT_ONE;
`endif
                    end
                end else begin
                    // Valid fell: the pointer already equals the stored byte count
                    rx_len_d = wr_ptr_q;
                    irq      = 1'b1;
                    state_d  = ST_READY;
                end
            end
            ST_READY: begin
                if (frame_start && drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_ONE;
                if (buf_release) begin
                    rx_ovf_d = 1'b0;
                    state_d  = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Host reads take the port only when no write is pending; one read in flight
    always_comb begin
        rd_grant = rd_req & ~wr_en & ~rd_ack_q;
        rd_ack_d = rd_grant;
    end

    // Memory port drive: write wins, otherwise the granted read address
    always_comb begin
        mem_en    = wr_en | rd_grant;
        mem_we    = wr_en;
        mem_addr  = '0;
        if (wr_en) begin
            mem_addr = wr_addr;
        end else if (rd_grant) begin
            mem_addr = rd_addr;
        end
        mem_wdata = wr_en ? rx_udp_data : '0;
    end

    // State registers; in_frame tracks valid through reset so a running frame is skipped
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_EMPTY;
            in_frame_q  <= rx_udp_data_v;
            wr_ptr_q    <= '0;
            rx_len_q    <= '0;
            rx_ovf_q    <= 1'b0;
            drop_cnt_q  <= '0;
            rd_ack_q    <= 1'b0;
`ifdef RX_MEM_STATS_EN
            frame_cnt_q <= '0;
            ovf_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_frame_q  <= in_frame_d;
            wr_ptr_q    <= wr_ptr_d;
            rx_len_q    <= rx_len_d;
            rx_ovf_q    <= rx_ovf_d;
            drop_cnt_q  <= drop_cnt_d;
            rd_ack_q    <= rd_ack_d;
`ifdef RX_MEM_STATS_EN
            frame_cnt_q <= frame_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
`endif
        end
    end

    assign rd_ack    = rd_ack_q;
    assign rd_data   = rd_ack_q ? mem_rdata : '0;
    assign buf_ready = (state_q == ST_READY);
    assign rx_len    = rx_len_q;
    assign rx_ovf    = rx_ovf_q;
    assign rx_irq    = irq;
    assign drop_cnt  = drop_cnt_q;
`ifdef RX_MEM_STATS_EN
    assign rx_frame_cnt = frame_cnt_q;
    assign ovf_cnt      = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_rx_mem_ctrl.sv
// tb/tb_rx_mem_ctrl.sv - self-checking bench for rx_mem_ctrl
module tb_rx_mem_ctrl;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [7:0]  data;
    logic        rd_req;
    logic [10:0] rd_addr;
    logic        rd_ack;
    logic [7:0]  rd_data;
    logic        buf_release;
    logic        mem_en;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        buf_ready;
    logic [11:0] rx_len;
    logic        rx_ovf;
    logic        rx_irq;
    logic [15:0] drop_cnt;
`ifdef RX_MEM_STATS_EN
    logic [15:0] rx_frame_cnt;
    logic [15:0] ovf_cnt;
`endif

    always #5 clk = ~clk;

    rx_mem_ctrl dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .rx_udp_data_v (valid),
        .rx_udp_data   (data),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_ack        (rd_ack),
        .rd_data       (rd_data),
        .buf_release   (buf_release),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .buf_ready     (buf_ready),
        .rx_len        (rx_len),
        .rx_ovf        (rx_ovf),
        .rx_irq        (rx_irq),
`ifdef RX_MEM_STATS_EN
        .drop_cnt      (drop_cnt),
        .rx_frame_cnt  (rx_frame_cnt),
        .ovf_cnt       (ovf_cnt)
`else
        .drop_cnt      (drop_cnt)
`endif
    );

    logic [7:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         wq_addr[$];
    logic [7:0] wq_data[$];
    int         gq_cyc[$];
    bit         gq_v[$];
    int         aq_cyc[$];
    logic [7:0] aq_data[$];
    int         irq_n;
    int         irq_cyc;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_en && mem_we) begin
                wq_addr.push_back(int'(mem_addr));
                wq_data.push_back(mem_wdata);
            end
            if (mem_en && !mem_we) begin
                gq_cyc.push_back(cyc);
                gq_v.push_back(valid);
            end
            if (rd_ack) begin
                aq_cyc.push_back(cyc);
                aq_data.push_back(rd_data);
            end
            if (rx_irq) begin
                irq_n   = irq_n + 1;
                irq_cyc = cyc;
            end
        end
    end

    logic [7:0] exp_mem [DEPTH];
    bit         m_full;
    int         m_len;
    bit         m_ovf;
    int         m_drop;
    int         m_acc;
    int         m_ovfn;
    logic [7:0] fb[$];
    int         end_cyc;
    int         n_chk = 0;
    int         n_pass = 0;

    function automatic void model_reset();
        m_full = 0; m_len = 0; m_ovf = 0; m_drop = 0; m_acc = 0; m_ovfn = 0;
    endfunction

    function automatic void model_release();
        m_full = 0;
        m_ovf  = 0;
    endfunction

    function automatic void model_frame(input bit rel_at_start);
        int n;
        if (m_full) begin
            if (m_drop < 65535) m_drop++;
            if (rel_at_start) model_release();
        end else begin
            n = (fb.size() > DEPTH) ? DEPTH : fb.size();
            for (int i = 0; i < n; i++) exp_mem[i] = fb[i];
            m_len  = n;
            m_ovf  = (fb.size() > DEPTH);
            m_full = 1;
            m_acc++;
            if (m_ovf) m_ovfn++;
        end
    endfunction

    function automatic void clear_logs();
        wq_addr.delete(); wq_data.delete(); gq_cyc.delete(); gq_v.delete();
        aq_cyc.delete(); aq_data.delete(); irq_n = 0; irq_cyc = -1;
    endfunction

    function automatic int wr_errs(input int n);
        int e = 0;
        if (wq_addr.size() != n) e++;
        for (int i = 0; i < wq_addr.size() && i < n; i++)
            if (wq_addr[i] != i || wq_data[i] !== fb[i]) e++;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int len, input bit incr, input int rd_at,
                              input logic [10:0] ra, input int rel_at);
        fb.delete();
        for (int i = 0; i < len; i++) begin
            tick();
            buf_release = 1'b0;
            valid = 1'b1;
            data  = incr ? 8'(i) : 8'($urandom);
            fb.push_back(data);
            if (i == rd_at) begin rd_req = 1'b1; rd_addr = ra; end
            if (i == rel_at) buf_release = 1'b1;
        end
        tick();
        buf_release = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        end_cyc = cyc;
    endtask

    task automatic do_read(input logic [10:0] a, output logic [7:0] d,
                           output int lat, output int ngr, output bit got);
        gq_cyc.delete(); gq_v.delete(); aq_cyc.delete(); aq_data.delete();
        tick();
        rd_req = 1'b1; rd_addr = a; got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (aq_cyc.size() > 0) begin got = 1; break; end
        end
        tick();
        rd_req = 1'b0;
        d   = got ? aq_data[0] : 8'hxx;
        lat = (got && gq_cyc.size() > 0) ? aq_cyc[0] - gq_cyc[0] : -1;
        ngr = gq_cyc.size();
    endtask

    task automatic release_buf();
        tick();
        buf_release = 1'b1;
        tick();
        buf_release = 1'b0;
        model_release();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; data = 8'hA5; rd_req = 1'b0; rd_addr = '0; buf_release = 1'b0;
        model_reset();
        tick(); tick();
        n_chk++; if ({buf_ready, rx_ovf, rx_irq, rd_ack, mem_en, mem_we} !== 6'b0) $display("FAIL rst_flags: got=%b exp=000000", {buf_ready, rx_ovf, rx_irq, rd_ack, mem_en, mem_we}); else n_pass++;
        n_chk++; if (rx_len !== 12'd0 || drop_cnt !== 16'd0) $display("FAIL rst_counts: len=%0d drop=%0d exp=0/0", rx_len, drop_cnt); else n_pass++;
        n_chk++; if (mem_addr !== 11'd0 || mem_wdata !== 8'd0 || rd_data !== 8'd0) $display("FAIL rst_bus: addr=%0d wdata=%0h rdata=%0h exp=0", mem_addr, mem_wdata, rd_data); else n_pass++;
        tick();
        rst_n = 1'b1; data = 8'h00;
        tick();
    endtask

    task automatic test_frame64();
        clear_logs();
        send_frame(64, 1'b1, -1, '0, -1);
        model_frame(1'b0);
        tick();
        n_chk++; if (wr_errs(64) != 0) $display("FAIL f64_writes: errs=%0d nwr=%0d exp=0/64", wr_errs(64), wq_addr.size()); else n_pass++;
        n_chk++; if (irq_n != 1 || irq_cyc != end_cyc) $display("FAIL f64_irq: n=%0d cyc=%0d exp=1/%0d", irq_n, irq_cyc, end_cyc); else n_pass++;
        n_chk++; if (buf_ready !== 1'b1 || rx_len !== 12'(m_len) || rx_ovf !== m_ovf) $display("FAIL f64_status: rdy=%b len=%0d ovf=%b exp=1/%0d/%b", buf_ready, rx_len, rx_ovf, m_len, m_ovf); else n_pass++;
    endtask

    task automatic test_reads();
        int         addrs [3] = '{0, 31, 63};
        logic [7:0] d;
        int         lat, ngr;
        bit         got;
        for (int i = 0; i < 3; i++) begin
            do_read(11'(addrs[i]), d, lat, ngr, got);
            n_chk++; if (!got || lat != 1 || ngr != 1) $display("FAIL rd_timing[%0d]: got=%b lat=%0d grants=%0d exp=1/1/1", addrs[i], got, lat, ngr); else n_pass++;
            n_chk++; if (d !== exp_mem[addrs[i]]) $display("FAIL rd_data[%0d]: got=%0h exp=%0h", addrs[i], d, exp_mem[addrs[i]]); else n_pass++;
        end
    endtask

    task automatic test_read_midframe();
        int  vgr = 0;
        bit  got = 0;
        release_buf();
        clear_logs();
        send_frame(40, 1'b0, 10, 11'd5, -1);
        model_frame(1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (aq_cyc.size() > 0) begin got = 1; break; end
        end
        tick();
        rd_req = 1'b0;
        foreach (gq_v[i]) if (gq_v[i]) vgr++;
        n_chk++; if (vgr != 0) $display("FAIL mid_no_grant: grants_with_valid=%0d exp=0", vgr); else n_pass++;
        n_chk++; if (!got || gq_cyc.size() == 0 || gq_cyc[0] != end_cyc || aq_cyc[0] != end_cyc + 1) $display("FAIL mid_timing: got=%b grant=%0d ack=%0d exp=%0d/%0d", got, (gq_cyc.size() > 0) ? gq_cyc[0] : -1, got ? aq_cyc[0] : -1, end_cyc, end_cyc + 1); else n_pass++;
        n_chk++; if (!got || aq_data[0] !== exp_mem[5]) $display("FAIL mid_data: got=%0h exp=%0h", got ? aq_data[0] : 8'hxx, exp_mem[5]); else n_pass++;
        n_chk++; if (wr_errs(40) != 0 || rx_len !== 12'(m_len)) $display("FAIL mid_frame: errs=%0d len=%0d exp=0/%0d", wr_errs(40), rx_len, m_len); else n_pass++;
    endtask

    task automatic test_drop();
        clear_logs();
        for (int f = 0; f < 3; f++) begin
            tick(); tick();
            send_frame($urandom_range(5, 30), 1'b0, -1, '0, -1);
            model_frame(1'b0);
        end
        tick();
        n_chk++; if (drop_cnt !== 16'(m_drop) || wq_addr.size() != 0 || buf_ready !== 1'b1) $display("FAIL drop3: drop=%0d nwr=%0d rdy=%b exp=%0d/0/1", drop_cnt, wq_addr.size(), buf_ready, m_drop); else n_pass++;
        tick();
        send_frame(6, 1'b0, -1, '0, 0);
        model_frame(1'b1);
        tick();
        n_chk++; if (drop_cnt !== 16'(m_drop) || buf_ready !== 1'b0 || wq_addr.size() != 0) $display("FAIL drop_rel: drop=%0d rdy=%b nwr=%0d exp=%0d/0/0", drop_cnt, buf_ready, wq_addr.size(), m_drop); else n_pass++;
        tick();
        send_frame(20, 1'b0, -1, '0, -1);
        model_frame(1'b0);
        tick();
        n_chk++; if (wr_errs(20) != 0 || rx_len !== 12'(m_len)) $display("FAIL drop_next: errs=%0d len=%0d exp=0/%0d", wr_errs(20), rx_len, m_len); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [10:0] a;
        logic [7:0]  d;
        int          lat, ngr;
        bit          got;
        release_buf();
        clear_logs();
        send_frame(DEPTH + 10, 1'b0, -1, '0, -1);
        model_frame(1'b0);
        tick();
        n_chk++; if (wr_errs(DEPTH) != 0) $display("FAIL ovf_writes: errs=%0d nwr=%0d exp=0/%0d", wr_errs(DEPTH), wq_addr.size(), DEPTH); else n_pass++;
        n_chk++; if (rx_len !== 12'(m_len) || rx_ovf !== m_ovf || irq_n != 1) $display("FAIL ovf_status: len=%0d ovf=%b irq=%0d exp=%0d/%b/1", rx_len, rx_ovf, irq_n, m_len, m_ovf); else n_pass++;
`ifdef RX_MEM_STATS_EN
        n_chk++; if (rx_frame_cnt !== 16'(m_acc) || ovf_cnt !== 16'(m_ovfn)) $display("FAIL stats: frames=%0d ovfs=%0d exp=%0d/%0d", rx_frame_cnt, ovf_cnt, m_acc, m_ovfn); else n_pass++;
`endif
        for (int i = 0; i < 4; i++) begin
            a = 11'($urandom_range(0, DEPTH - 1));
            do_read(a, d, lat, ngr, got);
            n_chk++; if (!got || lat != 1 || d !== exp_mem[a]) $display("FAIL ovf_read[%0d]: got=%b lat=%0d data=%0h exp=1/1/%0h", a, got, lat, d, exp_mem[a]); else n_pass++;
        end
        release_buf();
        n_chk++; if (rx_ovf !== 1'b0 || rx_len !== 12'(m_len) || buf_ready !== 1'b0) $display("FAIL ovf_release: ovf=%b len=%0d rdy=%b exp=0/%0d/0", rx_ovf, rx_len, buf_ready, m_len); else n_pass++;
    endtask

    task automatic test_reset_valid_high();
        tick();
        valid = 1'b1; data = 8'($urandom);
        rst_n = 1'b0;
        model_reset();
        tick(); tick();
        data = 8'($urandom);
        rst_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            tick();
            data = 8'($urandom);
        end
        tick();
        valid = 1'b0;
        tick();
        n_chk++; if (wq_addr.size() != 0 || buf_ready !== 1'b0 || rx_len !== 12'd0) $display("FAIL rvh_ignore: nwr=%0d rdy=%b len=%0d exp=0/0/0", wq_addr.size(), buf_ready, rx_len); else n_pass++;
        send_frame(8, 1'b0, -1, '0, -1);
        model_frame(1'b0);
        tick();
        n_chk++; if (wr_errs(8) != 0 || rx_len !== 12'(m_len)) $display("FAIL rvh_next: errs=%0d len=%0d exp=0/%0d", wr_errs(8), rx_len, m_len); else n_pass++;
    endtask

    task automatic test_reset_in_recv();
        logic [7:0] d;
        int         lat, ngr;
        bit         got;
        release_buf();
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            tick();
            valid = 1'b1; data = 8'($urandom);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++; if ({mem_en, mem_we, buf_ready, rx_irq} !== 4'b0 || rx_len !== 12'd0 || drop_cnt !== 16'd0) $display("FAIL rir_clear: flags=%b len=%0d drop=%0d exp=0000/0/0", {mem_en, mem_we, buf_ready, rx_irq}, rx_len, drop_cnt); else n_pass++;
        tick();
        valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
        send_frame(12, 1'b0, -1, '0, -1);
        model_frame(1'b0);
        tick();
        n_chk++; if (wr_errs(12) != 0 || rx_len !== 12'(m_len)) $display("FAIL rir_next: errs=%0d len=%0d exp=0/%0d", wr_errs(12), rx_len, m_len); else n_pass++;
        do_read(11'd0, d, lat, ngr, got);
        n_chk++; if (!got || d !== exp_mem[0]) $display("FAIL rir_read0: got=%b data=%0h exp=1/%0h", got, d, exp_mem[0]); else n_pass++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame64();
        test_reads();
        test_read_midframe();
        test_drop();
        test_overflow();
        test_reset_valid_high();
        test_reset_in_recv();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
